// File: rtl/v_tile_pkg.sv
// Shared types for the v_tile scheduler: FSM state encoding, dest field width
// and the default-sized lane vector alias.
package v_tile_pkg;

  localparam int DEST_W   = 4;
  localparam int VT_WIDTH = 16;
  localparam int VT_LANES = 4;

  typedef logic [VT_LANES-1:0][VT_WIDTH-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    OPS,
    FIRE,
    RESP
  } sched_state_e;

endpackage

// File: rtl/v_tile_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int num_req = 4,
  localparam int IDX_W   = $clog2(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [num_req-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(num_req);

  logic [num_req-1:0][IDX_W-1:0] cand;
  logic [num_req-1:0]            req_rot;

  // req_rot[k] is the request k positions after ptr
  for (genvar gi = 0; gi < num_req; gi++) begin : g_rot
    localparam logic [IDX_W:0] OFF = (IDX_W+1)'(gi);
    logic [IDX_W:0] sum;
    logic [IDX_W:0] wrapped;
    assign sum         = {1'b0, ptr} + OFF;
    assign wrapped     = sum - N_L;
    assign cand[gi]    = (sum >= N_L) ? wrapped[IDX_W-1:0] : sum[IDX_W-1:0];
    assign req_rot[gi] = req[cand[gi]];
  end

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = num_req - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        idx = cand[i];
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/v_tile_sched.sv
// Round-robin job scheduler sharing one v_tile: grant, config write, operand
// writes, fire with timeout, then hold the result until the consumer takes it.
module v_tile_sched
  import v_tile_pkg::*;
#(
  parameter  int width          = 16,
  parameter  int num_inputs     = 4,
  parameter  int num_req        = 4,
  parameter  int timeout_cycles = 64,
  localparam int ID_W           = $clog2(num_req)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [num_req-1:0]                           req_valid,
  input  logic [num_req-1:0][width-1:0]                req_cfg,
  input  logic [num_req-1:0][num_inputs-1:0][width-1:0] req_va,
  input  logic [num_req-1:0][num_inputs-1:0][width-1:0] req_vb,
  output logic [num_req-1:0]                           req_grant,
  output logic                                         cfg_en,
  input  logic                                         cfg_rdy,
  input  logic                                         cfg_ack,
  output logic [width-1:0]                             cfg_data,
  output logic                                         va_en,
  input  logic                                         va_rdy,
  input  logic                                         va_ack,
  output logic [num_inputs-1:0][width-1:0]             va_data,
  output logic                                         vb_en,
  input  logic                                         vb_rdy,
  input  logic                                         vb_ack,
  output logic [num_inputs-1:0][width-1:0]             vb_data,
  output logic                                         tile_on,
  input  logic                                         tile_ack,
  input  logic [num_inputs-1:0][width-1:0]             tile_out,
  input  logic [DEST_W-1:0]                            tile_dest,
  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [num_inputs-1:0][width-1:0]             res_data,
  output logic [ID_W-1:0]                              res_id,
  output logic [DEST_W-1:0]                            res_dest,
  output logic                                         res_err,
  output logic                                         busy
);

  localparam int             CNT_W    = $clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(num_req - 1);

  sched_state_e                     state_reg;
  logic [ID_W-1:0]                  ptr_reg;
  logic [num_req-1:0]               req_grant_reg;
  logic [width-1:0]                 cfg_data_reg;
  logic [num_inputs-1:0][width-1:0] va_data_reg;
  logic [num_inputs-1:0][width-1:0] vb_data_reg;
  logic                             va_done_reg;
  logic                             vb_done_reg;
  logic                             tile_on_reg;
  logic [CNT_W-1:0]                 cnt_reg;
  logic                             res_valid_reg;
  logic [num_inputs-1:0][width-1:0] res_data_reg;
  logic [ID_W-1:0]                  res_id_reg;
  logic [DEST_W-1:0]                res_dest_reg;
  logic                             res_err_reg;

  logic [num_req-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  rr_arbiter #(.num_req(num_req)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      req_grant_reg <= '0;
      cfg_data_reg  <= '0;
      va_data_reg   <= '0;
      vb_data_reg   <= '0;
      va_done_reg   <= 1'b0;
      vb_done_reg   <= 1'b0;
      tile_on_reg   <= 1'b0;
      cnt_reg       <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
      res_dest_reg  <= '0;
      res_err_reg   <= 1'b0;
    end else begin
      req_grant_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            cfg_data_reg  <= req_cfg[arb_idx];
            va_data_reg   <= req_va[arb_idx];
            vb_data_reg   <= req_vb[arb_idx];
            req_grant_reg <= arb_grant;
            res_id_reg    <= arb_idx;
            state_reg     <= CFG;
          end
        end
        CFG: begin
          if (cfg_ack) state_reg <= OPS;
        end
        OPS: begin
          // Ports finish independently; advance once both have been acked
          va_done_reg <= va_done_reg | va_ack;
          vb_done_reg <= vb_done_reg | vb_ack;
          if ((va_done_reg | va_ack) && (vb_done_reg | vb_ack)) begin
            va_done_reg <= 1'b0;
            vb_done_reg <= 1'b0;
            tile_on_reg <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= FIRE;
          end
        end
        FIRE: begin
          if (tile_ack) begin
            res_data_reg  <= tile_out;
            res_dest_reg  <= tile_dest;
            res_err_reg   <= 1'b0;
            tile_on_reg   <= 1'b0;
            res_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            res_data_reg  <= '0;
            res_err_reg   <= 1'b1;
            tile_on_reg   <= 1'b0;
            res_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            ptr_reg       <= (res_id_reg == ID_LAST) ? '0 : res_id_reg + 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write enables follow the tile's ready directly so a stalled port never fires
  assign cfg_en    = (state_reg == CFG) && cfg_rdy;
  assign va_en     = (state_reg == OPS) && va_rdy && !va_done_reg;
  assign vb_en     = (state_reg == OPS) && vb_rdy && !vb_done_reg;
  assign req_grant = req_grant_reg;
  assign cfg_data  = cfg_data_reg;
  assign va_data   = va_data_reg;
  assign vb_data   = vb_data_reg;
  assign tile_on   = tile_on_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign res_dest  = res_dest_reg;
  assign res_err   = res_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule
